// File: rtl/countdown_timer.sv
// Prescaled down-counter with one-shot or auto-reload operation.
// Emits a one-cycle done pulse when the count reaches its terminal value.
module countdown_timer #(
   parameter int NUM_BITS      = 8,
   parameter int PRESCALE_BITS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     load,
   input  logic [NUM_BITS-1:0]      load_value,
   input  logic                     periodic,
   input  logic [PRESCALE_BITS-1:0] prescale,
   output logic [NUM_BITS-1:0]      count,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                   state;
   logic [NUM_BITS-1:0]      reload;
   logic [PRESCALE_BITS-1:0] prescaler;

   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= '0;
         reload    <= '0;
         prescaler <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            count     <= load_value;
            reload    <= load_value;
            prescaler <= '0;
            state     <= (load_value != '0) ? RUN : IDLE;
         end else if (state == RUN && enable) begin
            // >= lets a mid-run prescale reduction tick at once instead of wrapping
            if (prescaler >= prescale) begin
               prescaler <= '0;
               if (count > NUM_BITS'(1)) begin
                  count <= count - NUM_BITS'(1);
               end else if (count == NUM_BITS'(1)) begin
                  done <= 1'b1;
                  if (periodic) begin
                     count <= reload;
                  end else begin
                     count <= '0;
                     state <= IDLE;
                  end
               end else begin
                  state <= IDLE;
               end
            end else begin
               prescaler <= prescaler + PRESCALE_BITS'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: per-cycle vector table plus
// hand-written sequences for pause, auto-reload, load-vs-terminal and async reset.
module tb_countdown_timer;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       load;
   logic [7:0] load_value;
   logic       periodic;
   logic [3:0] prescale;
   logic [7:0] count;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   countdown_timer #(.NUM_BITS(8), .PRESCALE_BITS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .load_value (load_value),
      .periodic   (periodic),
      .prescale   (prescale),
      .count      (count),
      .busy       (busy),
      .done       (done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       r;
      logic       en;
      logic       ld;
      logic [7:0] lv;
      logic       per;
      logic [3:0] pre;
      logic [7:0] ec;
      logic       eb;
      logic       ed;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input string name, input logic r, en, ld,
                               input logic [7:0] lv, input logic per,
                               input logic [3:0] pre, input logic [7:0] ec,
                               input logic eb, ed);
      vec_t v;
      v.name = name; v.r = r; v.en = en; v.ld = ld; v.lv = lv; v.per = per;
      v.pre = pre; v.ec = ec; v.eb = eb; v.ed = ed;
      tbl.push_back(v);
   endfunction

   // driver: set inputs away from the edge, return just after the next rising edge
   task automatic apply(input logic r, en, ld, input logic [7:0] lv,
                        input logic per, input logic [3:0] pre);
      @(negedge clk);
      rst = r; enable = en; load = ld; load_value = lv; periodic = per; prescale = pre;
      @(posedge clk);
      #1;
   endtask

   // scoreboard comparison
   task automatic expect_out(input string name, input logic [7:0] ec,
                             input logic eb, ed);
      n_checks++;
      if (count !== ec || busy !== eb || done !== ed) begin
         n_fail++;
         $display("FAIL %s: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                  name, count, busy, done, ec, eb, ed);
      end
   endtask

   initial begin
      int pause_exp[4];
      int per_exp[9];
      logic [8:0] per_done;

      rst = 1'b1; enable = 1'b1; load = 1'b0; load_value = '0;
      periodic = 1'b0; prescale = '0;
      #2 rst = 1'b0;
      #1 expect_out("reset_immediate", 8'd0, 1'b0, 1'b0);

      // reset held, inputs ignored
      add("rst_hold",      0, 1, 0, 8'd0, 0, 4'd0, 8'd0, 0, 0);
      add("rst_ignore_ld", 0, 1, 1, 8'd9, 0, 4'd0, 8'd0, 0, 0);
      add("rst_release",   1, 1, 0, 8'd9, 0, 4'd0, 8'd0, 0, 0);
      add("idle_enable",   1, 1, 0, 8'd9, 1, 4'd0, 8'd0, 0, 0);
      // load 5, prescale 0, one-shot
      add("p0_load",  1, 1, 1, 8'd5, 0, 4'd0, 8'd5, 1, 0);
      add("p0_4",     1, 1, 0, 8'd0, 0, 4'd0, 8'd4, 1, 0);
      add("p0_3",     1, 1, 0, 8'd0, 0, 4'd0, 8'd3, 1, 0);
      add("p0_2",     1, 1, 0, 8'd0, 0, 4'd0, 8'd2, 1, 0);
      add("p0_1",     1, 1, 0, 8'd0, 0, 4'd0, 8'd1, 1, 0);
      add("p0_0done", 1, 1, 0, 8'd0, 0, 4'd0, 8'd0, 0, 1);
      add("p0_after", 1, 1, 0, 8'd0, 0, 4'd0, 8'd0, 0, 0);
      add("p0_nowrap",1, 1, 0, 8'd0, 0, 4'd0, 8'd0, 0, 0);
      // load 3, prescale 2: each value held three cycles
      add("p2_load",  1, 1, 1, 8'd3, 0, 4'd2, 8'd3, 1, 0);
      add("p2_3a",    1, 1, 0, 8'd0, 0, 4'd2, 8'd3, 1, 0);
      add("p2_3b",    1, 1, 0, 8'd0, 0, 4'd2, 8'd3, 1, 0);
      add("p2_2a",    1, 1, 0, 8'd0, 0, 4'd2, 8'd2, 1, 0);
      add("p2_2b",    1, 1, 0, 8'd0, 0, 4'd2, 8'd2, 1, 0);
      add("p2_2c",    1, 1, 0, 8'd0, 0, 4'd2, 8'd2, 1, 0);
      add("p2_1a",    1, 1, 0, 8'd0, 0, 4'd2, 8'd1, 1, 0);
      add("p2_1b",    1, 1, 0, 8'd0, 0, 4'd2, 8'd1, 1, 0);
      add("p2_1c",    1, 1, 0, 8'd0, 0, 4'd2, 8'd1, 1, 0);
      add("p2_done",  1, 1, 0, 8'd0, 0, 4'd2, 8'd0, 0, 1);
      add("p2_after", 1, 1, 0, 8'd0, 0, 4'd2, 8'd0, 0, 0);
      // prescale reduced mid-run ticks on the next enabled cycle
      add("pr_load",  1, 1, 1, 8'd5, 0, 4'd3, 8'd5, 1, 0);
      add("pr_5a",    1, 1, 0, 8'd0, 0, 4'd3, 8'd5, 1, 0);
      add("pr_5b",    1, 1, 0, 8'd0, 0, 4'd3, 8'd5, 1, 0);
      add("pr_cut",   1, 1, 0, 8'd0, 0, 4'd0, 8'd4, 1, 0);
      add("pr_3",     1, 1, 0, 8'd0, 0, 4'd0, 8'd3, 1, 0);
      // loading zero returns to idle
      add("ld_zero",  1, 1, 1, 8'd0, 0, 4'd0, 8'd0, 0, 0);
      add("zero_idle",1, 1, 0, 8'd0, 0, 4'd0, 8'd0, 0, 0);

      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].en, tbl[i].ld, tbl[i].lv, tbl[i].per, tbl[i].pre);
         expect_out(tbl[i].name, tbl[i].ec, tbl[i].eb, tbl[i].ed);
      end

      // pause at count 4 for ten cycles, then resume
      apply(1, 1, 1, 8'd8, 0, 4'd0);
      expect_out("pause_load", 8'd8, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         apply(1, 1, 0, 8'd0, 0, 4'd0);
         expect_out("pause_run", 8'(7 - k), 1'b1, 1'b0);
      end
      for (int k = 0; k < 10; k++) begin
         apply(1, 0, 0, 8'd0, 0, 4'd0);
         expect_out("pause_hold", 8'd4, 1'b1, 1'b0);
      end
      pause_exp = '{3, 2, 1, 0};
      for (int k = 0; k < 4; k++) begin
         apply(1, 1, 0, 8'd0, 0, 4'd0);
         expect_out("pause_resume", 8'(pause_exp[k]), (k != 3), (k == 3));
      end

      // periodic reload, then one-shot stop after periodic is cleared
      apply(1, 1, 1, 8'd3, 1, 4'd0);
      expect_out("per_load", 8'd3, 1'b1, 1'b0);
      per_exp  = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
      per_done = 9'b100100100;
      for (int k = 0; k < 7; k++) begin
         apply(1, 1, 0, 8'd0, 1, 4'd0);
         expect_out("per_cycle", 8'(per_exp[k]), 1'b1, per_done[k]);
      end
      apply(1, 1, 0, 8'd0, 0, 4'd0);
      expect_out("per_clear_1", 8'd1, 1'b1, 1'b0);
      apply(1, 1, 0, 8'd0, 0, 4'd0);
      expect_out("per_clear_stop", 8'd0, 1'b0, 1'b1);
      apply(1, 1, 0, 8'd0, 0, 4'd0);
      expect_out("per_clear_idle", 8'd0, 1'b0, 1'b0);

      // load on the terminal-tick cycle wins, done suppressed
      apply(1, 1, 1, 8'd2, 0, 4'd0);
      expect_out("lt_load", 8'd2, 1'b1, 1'b0);
      apply(1, 1, 0, 8'd0, 0, 4'd0);
      expect_out("lt_1", 8'd1, 1'b1, 1'b0);
      apply(1, 1, 1, 8'd7, 0, 4'd0);
      expect_out("lt_override", 8'd7, 1'b1, 1'b0);
      apply(1, 1, 0, 8'd0, 0, 4'd0);
      expect_out("lt_6", 8'd6, 1'b1, 1'b0);

      // async reset mid-count: immediate clear, no done, ignored while low
      @(negedge clk);
      #2 rst = 1'b0;
      #1 expect_out("arst_immediate", 8'd0, 1'b0, 1'b0);
      apply(0, 1, 1, 8'd9, 1, 4'd0);
      expect_out("arst_held", 8'd0, 1'b0, 1'b0);
      apply(1, 1, 0, 8'd0, 0, 4'd0);
      expect_out("arst_release", 8'd0, 1'b0, 1'b0);
      apply(1, 1, 0, 8'd0, 0, 4'd0);
      expect_out("arst_quiet", 8'd0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
